// File: rtl/downmod12_ctl.sv
// Mod-12 down counter with periodic/one-shot modes, cascade borrow pulse,
// sticky illegal-load error flag and a saturating wrap counter.
module downmod12_ctl (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] a,
  input  logic       en,
  input  logic       mode,
  input  logic       clr_err,
  output logic [3:0] count,
  output logic       tc,
  output logic       borrow,
  output logic       done,
  output logic       err,
  output logic [7:0] wraps
);

  localparam logic [3:0] COUNT_MAX = 4'd11;
  localparam logic [7:0] WRAPS_MAX = 8'hFF;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

  state_e     state_q;
  logic [3:0] count_q;
  logic       borrow_q;
  logic       err_q;
  logic [7:0] wraps_q;

  // NOTE: every register below is assigned with <= so all of them update
  // from the same pre-edge values; a blocking = here would let later
  // statements see half-updated state and diverge from the netlist.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      count_q  <= 4'd0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
      wraps_q  <= 8'd0;
    end else begin
      borrow_q <= 1'b0;
      if (clr_err) begin
        err_q <= 1'b0;
      end
      if (load) begin
        // Later assignment to err_q overrides the clear: set wins.
        state_q <= RUN;
        if (a > COUNT_MAX) begin
          count_q <= COUNT_MAX;
          err_q   <= 1'b1;
        end else begin
          count_q <= a;
        end
      end else if (en && (state_q == RUN)) begin
        if (count_q != 4'd0) begin
          count_q <= count_q - 4'd1;
        end else if (!mode) begin
          count_q  <= COUNT_MAX;
          borrow_q <= 1'b1;
          if (wraps_q != WRAPS_MAX) begin
            wraps_q <= wraps_q + 8'd1;
          end
        end else begin
          state_q <= DONE;
        end
      end
    end
  end

  assign count  = count_q;
  assign tc     = (count_q == 4'd0);
  assign borrow = borrow_q;
  assign done   = (state_q == DONE);
  assign err    = err_q;
  assign wraps  = wraps_q;

endmodule
